// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: coprocessor-0 exception/interrupt unit at the M stage.
// It latches EPC/Cause.BD/ExcCode when an exception or interrupt is taken,
// services mtc0/mfc0/eret, and requests flush/redirect to HANDLER.
// Optional feature macro: CP0_BADVADDR_EN adds BadVAddr (reg 8), which loads
// the faulting address on AdEL/AdES.
module cp0_exc_unit #(
    parameter logic [31:0] PRID    = 32'h4D49_5053,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_m,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic [4:0]  exc_code_m,
    input  logic        eret_m,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    input  logic [5:0]  hw_int,
    input  logic [31:0] badvaddr_m,
    output logic [31:0] dout,
    output logic        int_req,
    output logic [31:0] handler_pc,
    output logic [31:0] epc_out
);

    typedef enum logic [4:0] {
        CP0_BADVADDR = 5'd8,
        CP0_SR       = 5'd12,
        CP0_CAUSE    = 5'd13,
        CP0_EPC      = 5'd14,
        CP0_PRID     = 5'd15
    } cp0_reg_e;

    // Status register fields
    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    // Cause register fields
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    // Exception PC
    logic [31:0] r_epc;

    logic        w_irq;
    logic        w_exc;
    logic        w_take;
    logic        w_wr_sr;
    logic        w_wr_epc;
    logic [31:0] w_sr_val;
    logic [31:0] w_cause_val;
    logic [31:0] w_epc_next;

    // Interrupt and exception qualification; EXL masks both.
    assign w_irq  = r_sr_ie & ~r_sr_exl & (|(hw_int & r_sr_im)) & valid_m;
    assign w_exc  = (exc_code_m != 5'd0) & ~r_sr_exl & valid_m;
    assign w_take = (w_irq | w_exc) & ~reset;

    // A taken exception squashes the writing instruction, so its mtc0 is dropped.
    assign w_wr_sr  = we & ~w_take & (addr == CP0_SR);
    assign w_wr_epc = we & ~w_take & (addr == CP0_EPC);

    // Delay-slot victims restart at the branch, one word earlier.
    assign w_epc_next = bd_m ? (pc_m - 32'd4) : pc_m;

    assign w_sr_val    = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
    assign w_cause_val = {r_cause_bd, 15'd0, r_cause_ip, 3'd0, r_cause_exc, 2'd0};

    assign int_req    = w_take;
    assign handler_pc = HANDLER;
    // Bypass lets an mtc0 EPC directly ahead of eret take effect.
    assign epc_out    = (we && (addr == CP0_EPC)) ? din : r_epc;

`ifdef CP0_BADVADDR_EN
    logic [31:0] r_badvaddr;
    logic        w_load_bva;

    assign w_load_bva = w_take & ~w_irq &
                        ((exc_code_m == 5'd4) | (exc_code_m == 5'd5));

    // BadVAddr captures the faulting address on address-error exceptions only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_badvaddr <= '0;
        end else if (w_load_bva) begin
            r_badvaddr <= badvaddr_m;
        end
    end
`else
    logic w_unused_badvaddr;
    assign w_unused_badvaddr = ^badvaddr_m;
`endif

    // Status register: exception entry sets EXL, eret clears it, mtc0 writes fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_im  <= '0;
            r_sr_exl <= 1'b0;
            r_sr_ie  <= 1'b0;
        end else if (w_take) begin
            r_sr_exl <= 1'b1;
        end else begin
            if (w_wr_sr) begin
                r_sr_im  <= din[15:10];
                r_sr_exl <= din[1];
                r_sr_ie  <= din[0];
            end
            if (eret_m) begin
                r_sr_exl <= 1'b0;
            end
        end
    end

    // Cause register: IP tracks hw_int, BD/ExcCode latched on exception entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= '0;
            r_cause_exc <= '0;
        end else begin
            r_cause_ip <= hw_int;
            if (w_take) begin
                r_cause_bd  <= bd_m;
                r_cause_exc <= w_irq ? 5'd0 : exc_code_m;
            end
        end
    end

    // EPC: exception entry has priority over an mtc0 write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_epc <= '0;
        end else if (w_take) begin
            r_epc <= w_epc_next;
        end else if (w_wr_epc) begin
            r_epc <= din;
        end
    end

    // mfc0 read mux; unimplemented registers read zero.
    always_comb begin
        dout = '0;
        case (addr)
`ifdef CP0_BADVADDR_EN
            CP0_BADVADDR: dout = r_badvaddr;
`endif
            CP0_SR:       dout = w_sr_val;
            CP0_CAUSE:    dout = w_cause_val;
            CP0_EPC:      dout = r_epc;
            CP0_PRID:     dout = PRID;
            default:      dout = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed self-checking bench for cp0_exc_unit.
module tb_cp0_exc_unit;

    localparam logic [31:0] PRID    = 32'h4D49_5053;
    localparam logic [31:0] HANDLER = 32'h0000_4180;

    logic        clk;
    logic        reset;
    logic        valid_m;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code_m;
    logic        eret_m;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [5:0]  hw_int;
    logic [31:0] badvaddr_m;
    logic [31:0] dout;
    logic        int_req;
    logic [31:0] handler_pc;
    logic [31:0] epc_out;

    int checks = 0;
    int errors = 0;

    cp0_exc_unit #(.PRID(PRID), .HANDLER(HANDLER)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_m    (valid_m),
        .pc_m       (pc_m),
        .bd_m       (bd_m),
        .exc_code_m (exc_code_m),
        .eret_m     (eret_m),
        .we         (we),
        .addr       (addr),
        .din        (din),
        .hw_int     (hw_int),
        .badvaddr_m (badvaddr_m),
        .dout       (dout),
        .int_req    (int_req),
        .handler_pc (handler_pc),
        .epc_out    (epc_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, dout, exp);
    endtask

    task automatic idle;
        valid_m = 1'b0; we = 1'b0; eret_m = 1'b0; exc_code_m = 5'd0;
        bd_m = 1'b0; din = '0;
    endtask

    initial begin
        logic [31:0] bva_exp;
        reset = 1'b1; valid_m = 1'b1; pc_m = '0; bd_m = 1'b0;
        exc_code_m = 5'd10; eret_m = 1'b0; we = 1'b0; addr = '0; din = '0;
        hw_int = '0; badvaddr_m = '0;

        // Reset state
        tick; tick;
        #1;
        chk("int_req_in_reset", {31'd0, int_req}, 32'd0);
        rd(5'd12, "rst_sr", 32'd0);
        rd(5'd13, "rst_cause", 32'd0);
        rd(5'd14, "rst_epc", 32'd0);
        rd(5'd15, "rst_prid", PRID);
        rd(5'd8, "rst_badvaddr", 32'd0);
        chk("handler_pc", handler_pc, HANDLER);
        idle;
        tick;
        reset = 1'b0;

        // mtc0 SR: IM[0], IE
        valid_m = 1'b1; we = 1'b1; addr = 5'd12; din = 32'h0000_0401;
        tick;
        // interrupt on hw_int[0]
        we = 1'b0; hw_int = 6'b000001; pc_m = 32'h3000; bd_m = 1'b0;
        #1;
        chk("irq_int_req", {31'd0, int_req}, 32'd1);
        tick;
        idle;
        rd(5'd14, "irq_epc", 32'h0000_3000);
        rd(5'd13, "irq_cause", 32'h0000_0400);
        rd(5'd12, "irq_sr", 32'h0000_0403);
        valid_m = 1'b1; #1;
        chk("exl_blocks_irq", {31'd0, int_req}, 32'd0);
        // eret clears EXL
        hw_int = '0; eret_m = 1'b1;
        tick;
        idle;
        rd(5'd12, "eret1_sr", 32'h0000_0401);
        tick;
        rd(5'd13, "ip_lag_clear", 32'd0);

        // Synchronous exception in a delay slot
        valid_m = 1'b1; exc_code_m = 5'd12; pc_m = 32'h3008; bd_m = 1'b1;
        #1;
        chk("exc_int_req", {31'd0, int_req}, 32'd1);
        tick;
        exc_code_m = 5'd10; pc_m = 32'h300C; bd_m = 1'b0;
        #1;
        chk("nested_exc_blocked", {31'd0, int_req}, 32'd0);
        idle;
        rd(5'd14, "bd_epc", 32'h0000_3004);
        rd(5'd13, "bd_cause", 32'h8000_0030);
        rd(5'd12, "exc_sr", 32'h0000_0403);

        // mtc0 EPC then eret
        valid_m = 1'b1; we = 1'b1; addr = 5'd14; din = 32'h3100;
        #1;
        chk("epc_bypass", epc_out, 32'h0000_3100);
        tick;
        we = 1'b0; din = '0; eret_m = 1'b1; addr = 5'd14;
        #1;
        chk("eret_epc_out", epc_out, 32'h0000_3100);
        chk("eret_no_int", {31'd0, int_req}, 32'd0);
        tick;
        idle;
        rd(5'd12, "eret2_sr", 32'h0000_0401);

        // Exception beats a same-cycle mtc0 EPC
        valid_m = 1'b1; we = 1'b1; addr = 5'd14; din = 32'h0000_DEAD;
        exc_code_m = 5'd4; pc_m = 32'h3200; bd_m = 1'b0; badvaddr_m = 32'h1234_5679;
        #1;
        chk("adel_int_req", {31'd0, int_req}, 32'd1);
        tick;
        idle;
        rd(5'd14, "adel_epc", 32'h0000_3200);
        rd(5'd13, "adel_cause", 32'h0000_0010);
`ifdef CP0_BADVADDR_EN
        bva_exp = 32'h1234_5679;
`else
        bva_exp = 32'd0;
`endif
        rd(5'd8, "adel_badvaddr", bva_exp);
        valid_m = 1'b1; eret_m = 1'b1;
        tick;
        idle;

        // EPC wrap: delay slot at address 0
        valid_m = 1'b1; exc_code_m = 5'd12; pc_m = 32'h0; bd_m = 1'b1;
        tick;
        idle;
        rd(5'd14, "wrap_epc", 32'hFFFF_FFFC);
        valid_m = 1'b1; eret_m = 1'b1;
        tick;
        idle;

        // Interrupt pending across bubbles
        hw_int = 6'b000001;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bubble_no_int", {31'd0, int_req}, 32'd0);
            tick;
        end
        valid_m = 1'b1; pc_m = 32'h3300; bd_m = 1'b0;
        exc_code_m = 5'd4; badvaddr_m = 32'hAAAA_0000; eret_m = 1'b1;
        #1;
        chk("pending_int_req", {31'd0, int_req}, 32'd1);
        tick;
        idle;
        hw_int = '0;
        rd(5'd14, "pending_epc", 32'h0000_3300);
        rd(5'd13, "irq_prio_cause", 32'h0000_0400);
        rd(5'd12, "int_beats_eret_sr", 32'h0000_0403);
        rd(5'd8, "irq_no_badvaddr", bva_exp);
        valid_m = 1'b1; eret_m = 1'b1;
        tick;
        idle;

        // mtc0 field masking and read-only Cause
        valid_m = 1'b1; we = 1'b1; addr = 5'd12; din = 32'hFFFF_FFFF;
        tick;
        idle;
        rd(5'd12, "sr_mask", 32'h0000_FC03);
        valid_m = 1'b1; we = 1'b1; addr = 5'd13; din = 32'hFFFF_FFFF;
        tick;
        idle;
        rd(5'd13, "cause_ro", 32'd0);
        rd(5'd5, "unmapped_reg", 32'd0);
        rd(5'd15, "prid_again", PRID);

        // Re-reset clears state
        reset = 1'b1;
        tick;
        reset = 1'b0;
        rd(5'd12, "rereset_sr", 32'd0);
        rd(5'd14, "rereset_epc", 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
